// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type and line-level bit
// values. The transmit framer and the receiver FSM both import this package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned PS_W = 6;

  // even_par is the XOR-reduction of the data word.
  function automatic logic par_bit(input logic typ, input logic even_par);
    return (typ == PAR_EVEN) ? even_par : ~even_par;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel-side and line-side signals of the UART transmitter.
//   P_DATA     word to transmit (sampled on accept)
//   DATA_VALID request to send P_DATA
//   PAR_EN     1 = parity bit inserted (sampled on accept)
//   PAR_TYP    0 = even, 1 = odd (sampled on accept)
//   prescale   CLK cycles per bit, 0 behaves as 1 (sampled on accept)
//   TX_OUT     registered serial line, idles high
//   busy       high while a frame is in progress
interface uart_tx_frame_if #(
  parameter int unsigned Data_width = 8
);
  import uart_pkg::*;

  logic [Data_width-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PS_W-1:0]       prescale;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter. On load it captures the bit period (0 treated as 1)
// and restarts at 0; while run is high it counts 0..ps-1 and wraps.
//   clk, rst  clock and synchronous active-high reset
//   load      accept strobe: capture ps, clear count
//   run       frame in progress
//   ps        requested cycles per bit
//   bit_done  high on the last cycle of the current bit
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            run,
  input  logic [PS_W-1:0] ps,
  output logic            bit_done
);

  logic [PS_W-1:0] ps_last;
  logic [PS_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      ps_last <= '0;
    end else if (load) begin
      count   <= '0;
      ps_last <= (ps == '0) ? '0 : ps - PS_W'(1);
    end else if (run) begin
      if (count == ps_last) count <= '0;
      else                  count <= count + PS_W'(1);
    end
  end

  assign bit_done = run && (count == ps_last);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per DATA_VALID while idle and sends
// start bit, Data_width data bits LSB first, optional parity, stop bit, each
// bit held for the latched prescale cycles.
//   CLK, RST  clock and synchronous active-high reset
//   bus       uart_tx_frame_if slave (parallel request side + TX_OUT/busy)
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned Data_width = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_frame_if.slave bus
);

  localparam int unsigned IW = (Data_width > 1) ? $clog2(Data_width) : 1;
  localparam logic [IW-1:0] LAST = IW'(Data_width - 1);

  uart_state_t           state, state_next;
  logic [Data_width-1:0] data_sh;
  logic                  par_en_sh, par_typ_sh;
  logic [IW-1:0]         idx, idx_next;
  logic                  tx, tx_next;
  logic                  busy_r, busy_next;
  logic                  accept, bit_done;

  assign accept = (state == IDLE) && bus.DATA_VALID;

  uart_tx_bit_timer u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .run      (state != IDLE),
    .ps       (bus.prescale),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      tx         <= STOP_BIT;
      busy_r     <= 1'b0;
      data_sh    <= '0;
      par_en_sh  <= 1'b0;
      par_typ_sh <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      tx     <= tx_next;
      busy_r <= busy_next;
      if (accept) begin
        data_sh    <= bus.P_DATA;
        par_en_sh  <= bus.PAR_EN;
        par_typ_sh <= bus.PAR_TYP;
      end
    end
  end

  // The line value for the next bit is computed here and registered, so
  // TX_OUT changes exactly on the edge the state advances.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    tx_next    = tx;
    busy_next  = busy_r;
    unique case (state)
      IDLE: if (bus.DATA_VALID) begin
        state_next = START;
        tx_next    = START_BIT;
        busy_next  = 1'b1;
        idx_next   = '0;
      end
      START: if (bit_done) begin
        state_next = DATA;
        tx_next    = data_sh[0];
        idx_next   = '0;
      end
      DATA: if (bit_done) begin
        if (idx == LAST) begin
          if (par_en_sh) begin
            state_next = PARITY;
            tx_next    = par_bit(par_typ_sh, ^data_sh);
          end else begin
            state_next = STOP;
            tx_next    = STOP_BIT;
          end
        end else begin
          idx_next = idx + IW'(1);
          tx_next  = data_sh[idx + IW'(1)];
        end
      end
      PARITY: if (bit_done) begin
        state_next = STOP;
        tx_next    = STOP_BIT;
      end
      STOP: if (bit_done) begin
        state_next = IDLE;
        tx_next    = STOP_BIT;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
        tx_next    = STOP_BIT;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = tx;
  assign bus.busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.Data_width(8)) bus ();

  uart_tx_frame #(.Data_width(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
    int         ps;
    bit         b2b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic busy_prev = 1'b0;
  int   last_idle_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / loopback receiver: pops the expected frame when busy rises and
  // checks every cycle of every bit, then the return to idle.
  initial begin : monitor
    exp_t e;
    int ps, nb, bad_c, start_cyc;
    logic [7:0] rxw;
    logic exp_b;
    forever begin
      @(negedge clk);
      if (mon_en && bus.busy === 1'b1 && busy_prev === 1'b0) begin
        start_cyc = cyc;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_frame", 1, 0);
        end else begin
          e  = q.pop_front();
          ps = (e.ps == 0) ? 1 : e.ps;
          nb = e.par_en ? 11 : 10;
          if (e.b2b)
            chk(start_cyc - last_idle_cyc == 1, "b2b_idle_gap",
                start_cyc - last_idle_cyc, 1);
          rxw = '0;
          for (int b = 0; b < nb; b++) begin
            if (b == 0)                     exp_b = 1'b0;
            else if (b <= 8)                exp_b = e.data[b-1];
            else if (b == 9 && e.par_en)    exp_b = e.par_bit;
            else                            exp_b = 1'b1;
            bad_c = 0;
            for (int c = 0; c < ps; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (bus.TX_OUT !== exp_b || bus.busy !== 1'b1) bad_c++;
              if (b >= 1 && b <= 8 && c == ps / 2) rxw[b-1] = bus.TX_OUT;
            end
            chk(bad_c == 0, $sformatf("bit%0d_data%02h_badcycles", b, e.data), bad_c, 0);
          end
          chk(rxw == e.data, "loopback_word", int'(rxw), int'(e.data));
          @(negedge clk);
          chk(bus.busy === 1'b0 && bus.TX_OUT === 1'b1, "frame_end_busy_tx",
              int'({bus.busy, bus.TX_OUT}), 1);
          last_idle_cyc = cyc;
        end
      end
      busy_prev = bus.busy;
    end
  end

  // Waits for the DUT to become idle (if busy) and then to accept.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic pb, input logic [5:0] ps, input bit hold,
                      input bit b2b, input bit disturb);
    exp_t e;
    int n;
    @(negedge clk);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.prescale   = ps;
    bus.DATA_VALID = 1'b1;
    e = '{d, pe, pb, int'(ps), b2b};
    q.push_back(e);
    n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    n = 0;
    while (bus.busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (bus.busy !== 1'b1) chk(1'b0, "accept_timeout", 0, 1);
    if (!hold) bus.DATA_VALID = 1'b0;
    if (disturb) begin
      bus.P_DATA   = 8'hFF;
      bus.PAR_EN   = ~pe;
      bus.PAR_TYP  = ~pt;
      bus.prescale = 6'd3;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    if (bus.busy !== 1'b0) chk(1'b0, "idle_timeout", 1, 0);
  endtask

  initial begin : stim
    int bad;
    rst            = 1'b1;
    bus.P_DATA     = '0;
    bus.DATA_VALID = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.prescale   = 6'd8;
    repeat (3) @(negedge clk);
    chk(bus.TX_OUT === 1'b1 && bus.busy === 1'b0, "reset_state",
        int'({bus.busy, bus.TX_OUT}), 1);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk(bad == 0, "idle_hold_badcycles", bad, 0);

    // Reset in the middle of a frame.
    @(negedge clk);
    bus.P_DATA = 8'hAB; bus.prescale = 6'd8; bus.DATA_VALID = 1'b1;
    @(negedge clk);
    bus.DATA_VALID = 1'b0;
    repeat (19) @(negedge clk);
    chk(bus.busy === 1'b1, "busy_before_midframe_reset", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk(bus.TX_OUT === 1'b1 && bus.busy === 1'b0, "midframe_reset",
        int'({bus.busy, bus.TX_OUT}), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // AB no parity, ps=8; DATA_VALID pulse while busy must be ignored.
    send(8'hAB, 1'b0, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.P_DATA = 8'h00; bus.DATA_VALID = 1'b1;
    repeat (3) @(negedge clk);
    bus.DATA_VALID = 1'b0;
    wait_idle();
    // AB: five ones -> even parity 1, odd parity 0.
    send(8'hAB, 1'b1, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0, 1'b0); wait_idle();
    send(8'hAB, 1'b1, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0, 1'b0); wait_idle();
    // 0F: four ones -> even 0, odd 1; inputs disturbed after accept.
    send(8'h0F, 1'b1, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0, 1'b1); wait_idle();
    send(8'h0F, 1'b1, 1'b1, 1'b1, 6'd32, 1'b0, 1'b0, 1'b0); wait_idle();
    // Back-to-back with DATA_VALID held high.
    send(8'hCD, 1'b0, 1'b0, 1'b0, 6'd8, 1'b1, 1'b0, 1'b0);
    send(8'hEF, 1'b0, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1, 1'b0);
    wait_idle();
    // prescale 0 -> single-cycle bits; 5A has four ones -> even parity 0.
    send(8'h5A, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0); wait_idle();

    repeat (20) @(negedge clk);
    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
